// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: speculative loads vs committed-store FIFO.
// Ports: clk/reset, flush, ld_* load req, st_* store push, mem_* port, rd_* result, idle.
module mem_port_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int LOAD_WAIT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ld_valid,
  input  logic [15:0] ld_location,
  output logic        ld_stall,
  input  logic        st_valid,
  input  logic [15:0] st_location,
  input  logic [15:0] st_data,
  output logic        st_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_location,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        idle
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SL = $clog2(STARVE_LIMIT + 1);
  localparam int SW = (SL > 4) ? SL : 4;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [15:0]          addr_q [FIFO_DEPTH];
  logic [15:0]          data_q [FIFO_DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;
  logic [SW-1:0]        starve_cnt;
  logic [LOAD_WAIT-1:0] rd_pipe;

  logic fifo_hit;
  logic push_hit;
  logic hazard;
  logic has_data;
  logic force_store;
  logic grant_load;
  logic grant_store;
  logic push;

  // Compare the load address against every live entry.
  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CW'(i) < count &&
          addr_q[head + PW'(i)] == ld_location)
        fifo_hit = 1'b1;
    end
  end

  assign push_hit = st_valid &&
                    (st_location == ld_location);
  assign hazard   = ld_valid && (fifo_hit || push_hit);
  assign has_data = (count != '0);
  assign st_stall = (count == FULL);
  assign push     = st_valid && !st_stall;

  assign force_store = has_data &&
                       (hazard || starve_cnt >= LIMIT);
  assign grant_load  = ld_valid && !force_store &&
                       !hazard && !flush && !reset;
  assign grant_store = !grant_load && has_data && !reset;

  assign ld_stall = ld_valid && !grant_load &&
                    !flush && !reset;

  always_comb begin
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_location = '0;
    mem_wdata    = '0;
    if (grant_load) begin
      mem_en       = 1'b1;
      mem_location = ld_location;
    end else if (grant_store) begin
      mem_en       = 1'b1;
      mem_we       = 1'b1;
      mem_location = addr_q[head];
      mem_wdata    = data_q[head];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + PW'(1);
      if (grant_store)
        head <= head + PW'(1);
      count <= count + CW'(push) - CW'(grant_store);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_location;
      data_q[tail] <= st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || grant_store || !has_data)
      starve_cnt <= '0;
    else if (grant_load && starve_cnt != '1)
      starve_cnt <= starve_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= grant_load;
      for (int i = 1; i < LOAD_WAIT; i++)
        rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // A read landing in the flush cycle itself is also dropped.
  assign rd_valid = rd_pipe[LOAD_WAIT-1] &&
                    !flush && !reset;
  assign rd_data  = rd_valid ? mem_rdata : '0;
  assign idle     = !has_data && (rd_pipe == '0);

endmodule
